// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter sequencer.
package morse_pkg;

   // Letter sequencing states; the encoding is also visible on dbg_state.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_EMIT    = 3'd2,
      ST_GAP     = 3'd3,
      ST_SPACE   = 3'd4
   } state_t;

   // Front-end symbol codes; 00 and 11 both mean "no symbol".
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b10;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_UNK   = 8'h3F;

   // Longest valid letter (digits are five symbols); one more means overflow.
   localparam int         MAX_LEN = 5;
   localparam logic [2:0] LEN_OVF = 3'd6;

endpackage

// File: rtl/morse_decode.sv
// Combinational (length, pattern) -> ASCII lookup for ITU letters and digits.
// Pattern holds the first symbol in the highest used bit; dot=0, dash=1.
module morse_decode
   import morse_pkg::*;
(
   input  logic [2:0]         i_len,
   input  logic [MAX_LEN-1:0] i_pat,
   output logic [7:0]         o_char
);

   logic [MAX_LEN-1:0] w_mask;
   logic [MAX_LEN-1:0] w_pat;
   logic [7:0]         w_key;

   // Ignore any pattern bits above the current length so stale bits cannot alias.
   assign w_mask = ~(5'b11111 << i_len);
   assign w_pat  = i_pat & w_mask;
   assign w_key  = {i_len, w_pat};

   // Lookup table; anything unlisted (including the overflow length) is '?'.
   always_comb begin
      o_char = ASCII_UNK;
      case (w_key)
         {3'd1, 5'b00000}: o_char = "E";
         {3'd1, 5'b00001}: o_char = "T";
         {3'd2, 5'b00000}: o_char = "I";
         {3'd2, 5'b00001}: o_char = "A";
         {3'd2, 5'b00010}: o_char = "N";
         {3'd2, 5'b00011}: o_char = "M";
         {3'd3, 5'b00000}: o_char = "S";
         {3'd3, 5'b00001}: o_char = "U";
         {3'd3, 5'b00010}: o_char = "R";
         {3'd3, 5'b00011}: o_char = "W";
         {3'd3, 5'b00100}: o_char = "D";
         {3'd3, 5'b00101}: o_char = "K";
         {3'd3, 5'b00110}: o_char = "G";
         {3'd3, 5'b00111}: o_char = "O";
         {3'd4, 5'b00000}: o_char = "H";
         {3'd4, 5'b00001}: o_char = "V";
         {3'd4, 5'b00010}: o_char = "F";
         {3'd4, 5'b00100}: o_char = "L";
         {3'd4, 5'b00110}: o_char = "P";
         {3'd4, 5'b00111}: o_char = "J";
         {3'd4, 5'b01000}: o_char = "B";
         {3'd4, 5'b01001}: o_char = "X";
         {3'd4, 5'b01010}: o_char = "C";
         {3'd4, 5'b01011}: o_char = "Y";
         {3'd4, 5'b01100}: o_char = "Z";
         {3'd4, 5'b01101}: o_char = "Q";
         {3'd5, 5'b11111}: o_char = "0";
         {3'd5, 5'b01111}: o_char = "1";
         {3'd5, 5'b00111}: o_char = "2";
         {3'd5, 5'b00011}: o_char = "3";
         {3'd5, 5'b00001}: o_char = "4";
         {3'd5, 5'b00000}: o_char = "5";
         {3'd5, 5'b10000}: o_char = "6";
         {3'd5, 5'b11000}: o_char = "7";
         {3'd5, 5'b11100}: o_char = "8";
         {3'd5, 5'b11110}: o_char = "9";
         default:          o_char = ASCII_UNK;
      endcase
   end

endmodule

// File: rtl/morse_letter_sequencer.sv
// Collects dot/dash symbols into letters, decodes them to ASCII, inserts a
// word space after a long idle gap, and buffers characters in a small FIFO.
//
// Output handshake: char_valid is high whenever the FIFO holds a character and
// char_data shows the head; the head is consumed on a rising clk edge where
// char_valid and char_ready are both high. char_valid never drops without a
// pop (except on reset), and char_data is stable while char_valid & !char_ready.
module morse_letter_sequencer
   import morse_pkg::*;
#(
   parameter int WORD_GAP = 7000,
   parameter int DEPTH    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       button,
   input  logic [1:0] morse_signal,
   input  logic       letter_spacing,
   output logic [7:0] char_data,
   output logic       char_valid,
   input  logic       char_ready,
   output logic       overrun,
   input  logic       err_clr,
   output logic [2:0] dbg_state
);

   localparam int AW = $clog2(DEPTH);

   // Edge detection and symbol capture
   logic               r_button_q;
   logic               r_ls_q;
   logic               r_cap_pend;
   logic               w_ls_rise;
   logic               w_sym_valid;
   logic               w_sym_bit;

   // Letter assembly
   state_t             r_state;
   state_t             w_next_state;
   logic [MAX_LEN-1:0] r_pat;
   logic [2:0]         r_len;
   logic [31:0]        r_gap_cnt;
   logic               w_gap_done;
   logic [7:0]         w_dec_char;

   // FSM-driven controls
   logic               w_push;
   logic [7:0]         w_push_data;
   logic               w_shift;
   logic               w_load_fresh;
   logic               w_clear;
   logic               w_gap_clr;
   logic               w_gap_run;

   // FIFO
   logic [7:0]         r_mem [DEPTH];
   logic [AW:0]        r_wr_ptr;
   logic [AW:0]        r_rd_ptr;
   logic               r_overrun;
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_wr_en;
   logic               w_drop;

   assign w_ls_rise   = ~r_ls_q & letter_spacing;
   assign w_sym_valid = r_cap_pend & ((morse_signal == SYM_DOT) | (morse_signal == SYM_DASH));
   assign w_sym_bit   = (morse_signal == SYM_DASH);
   assign w_gap_done  = (r_gap_cnt == 32'(WORD_GAP - 1));

   // Register the raw inputs; a button release arms capture for the next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_button_q <= 1'b0;
         r_ls_q     <= 1'b0;
         r_cap_pend <= 1'b0;
      end else begin
         r_button_q <= button;
         r_ls_q     <= letter_spacing;
         r_cap_pend <= r_button_q & ~button;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // FSM next-state logic; a fresh symbol always wins over gap timing.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:    if (w_sym_valid) w_next_state = ST_COLLECT;
         ST_COLLECT: if (w_ls_rise)   w_next_state = ST_EMIT;
         ST_EMIT:    w_next_state = w_sym_valid ? ST_COLLECT : ST_GAP;
         ST_GAP: begin
            if (w_sym_valid)     w_next_state = ST_COLLECT;
            else if (w_gap_done) w_next_state = ST_SPACE;
         end
         ST_SPACE:   w_next_state = w_sym_valid ? ST_COLLECT : ST_IDLE;
         default:    w_next_state = ST_IDLE;
      endcase
   end

   // FSM outputs: FIFO pushes and pattern/gap-counter controls.
   always_comb begin
      w_push       = 1'b0;
      w_push_data  = ASCII_SPACE;
      w_shift      = 1'b0;
      w_load_fresh = 1'b0;
      w_clear      = 1'b0;
      w_gap_clr    = 1'b0;
      w_gap_run    = 1'b0;
      case (r_state)
         ST_IDLE, ST_COLLECT: w_shift = w_sym_valid;
         ST_EMIT: begin
            w_push       = 1'b1;
            w_push_data  = w_dec_char;
            w_gap_clr    = 1'b1;
            w_load_fresh = w_sym_valid;
            w_clear      = ~w_sym_valid;
         end
         ST_GAP: begin
            w_gap_run    = 1'b1;
            w_load_fresh = w_sym_valid;
         end
         ST_SPACE: begin
            w_push       = 1'b1;
            w_push_data  = ASCII_SPACE;
            w_load_fresh = w_sym_valid;
         end
         default: ;
      endcase
   end

   // Pattern shift register and saturating length (LEN_OVF marks overflow).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pat <= '0;
         r_len <= '0;
      end else if (w_load_fresh) begin
         r_pat <= {{(MAX_LEN-1){1'b0}}, w_sym_bit};
         r_len <= 3'd1;
      end else if (w_shift) begin
         r_pat <= {r_pat[MAX_LEN-2:0], w_sym_bit};
         r_len <= (r_len >= LEN_OVF) ? LEN_OVF : r_len + 3'd1;
      end else if (w_clear) begin
         r_pat <= '0;
         r_len <= '0;
      end
   end

   // Idle-gap counter: restarts on a held button, saturates at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gap_cnt <= '0;
      end else if (w_gap_clr) begin
         r_gap_cnt <= '0;
      end else if (w_gap_run) begin
         if (button)                r_gap_cnt <= '0;
         else if (~&r_gap_cnt)      r_gap_cnt <= r_gap_cnt + 32'd1;
      end
   end

   morse_decode u_decode (
      .i_len  (r_len),
      .i_pat  (r_pat),
      .o_char (w_dec_char)
   );

   // FIFO status; a pop in the same cycle frees room for a push into a full FIFO.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = ~w_empty & char_ready;
   assign w_wr_en = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;

   // FIFO storage and pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_wr_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Sticky overrun flag; a new drop wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_overrun <= 1'b0;
      else if (w_drop)  r_overrun <= 1'b1;
      else if (err_clr) r_overrun <= 1'b0;
   end

   assign char_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign char_valid = ~w_empty;
   assign overrun    = r_overrun;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Bench for morse_letter_sequencer: directed tables, hand sequences for the
// timing corners, and random letters checked against a string-keyed Morse model.
module tb_morse_letter_sequencer;
  import morse_pkg::*;

  localparam int WORD_GAP = 40;
  localparam int DEPTH    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       button = 1'b0;
  logic [1:0] morse_signal = 2'b00;
  logic       letter_spacing = 1'b0;
  logic       char_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] char_data;
  logic       char_valid;
  logic       overrun;
  logic [2:0] dbg_state;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       exp_ovr = 1'b0;
  bit         pending_space = 1'b0;
  logic [7:0] mon_exp;
  logic [7:0] morse_map[string];

  string mc_tab[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                        "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                        "--...", "---..", "----."};

  typedef struct {
    string      syms;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  morse_letter_sequencer #(.WORD_GAP(WORD_GAP), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .button         (button),
    .morse_signal   (morse_signal),
    .letter_spacing (letter_spacing),
    .char_data      (char_data),
    .char_valid     (char_valid),
    .char_ready     (char_ready),
    .overrun        (overrun),
    .err_clr        (err_clr),
    .dbg_state      (dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_decode(input string s);
    if (s.len() > 5 || !morse_map.exists(s)) return 8'h3F;
    return morse_map[s];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One press/release; the front-end code is presented from the release onward.
  task automatic send_sym(input logic [1:0] code, input bit merge_ls);
    button = 1'b1;
    tick;
    tick;
    button = 1'b0;
    morse_signal = code;
    tick;
    if (merge_ls) letter_spacing = 1'b1;
    tick;
    morse_signal = 2'b00;
  endtask

  task automatic send_string(input string s, input bit merge_last);
    for (int i = 0; i < s.len(); i++)
      send_sym((s[i] == 8'h2D) ? SYM_DASH : SYM_DOT, merge_last && (i == s.len() - 1));
  endtask

  // Raise letter_spacing (unless already raised with the last symbol) and book the character.
  task automatic close_letter(input logic [7:0] exp_ch, input bit merged, input bit ready_at_emit);
    if (!ready_at_emit && !char_ready && exp_q.size() >= DEPTH) exp_ovr = 1'b1;
    else exp_q.push_back(exp_ch);
    if (!merged) begin
      letter_spacing = 1'b1;
      tick;
    end
    if (ready_at_emit) char_ready = 1'b1;
    tick;
    letter_spacing = 1'b0;
    pending_space = 1'b1;
  endtask

  task automatic letter(input string s, input logic [7:0] exp_ch);
    send_string(s, 1'b0);
    close_letter(exp_ch, 1'b0, 1'b0);
  endtask

  // Stay idle long enough for exactly one word space.
  task automatic word_gap;
    if (!char_ready && exp_q.size() >= DEPTH) exp_ovr = 1'b1;
    else exp_q.push_back(8'h20);
    repeat (WORD_GAP + 8) tick;
    pending_space = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && char_valid && char_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL char_stream: got 0x%0h expected no character", char_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (char_data !== mon_exp) begin
          errors++;
          $display("FAIL char_stream: got 0x%0h expected 0x%0h", char_data, mon_exp);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    string s;
    int    r;
    int    nl;

    for (int i = 0; i < 36; i++)
      morse_map[mc_tab[i]] = (i < 26) ? 8'(8'h41 + i) : 8'(8'h30 + i - 26);

    vecs[0]  = '{".-",      8'h41};
    vecs[1]  = '{"-...",    8'h42};
    vecs[2]  = '{"...",     8'h53};
    vecs[3]  = '{"-----",   8'h30};
    vecs[4]  = '{".----",   8'h31};
    vecs[5]  = '{"----.",   8'h39};
    vecs[6]  = '{"--..",    8'h5A};
    vecs[7]  = '{"-.--",    8'h59};
    vecs[8]  = '{"..--",    8'h3F};
    vecs[9]  = '{".-.-",    8'h3F};
    vecs[10] = '{"......",  8'h3F};
    vecs[11] = '{"-------", 8'h3F};

    // Reset state
    repeat (3) tick;
    check("rst_valid", char_valid, 0);
    check("rst_data", char_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dbg_state, 32'(ST_IDLE));
    rst_n = 1'b1;
    tick;
    char_ready = 1'b1;

    // A with letter latency: valid exactly two cycles after the ls_rise cycle
    send_string(".-", 1'b0);
    exp_q.push_back(8'h41);
    letter_spacing = 1'b1;
    @(negedge clk) check("lat_c0_valid", char_valid, 0);
    tick;
    @(negedge clk) begin
      check("lat_c1_valid", char_valid, 0);
      check("lat_c1_state", dbg_state, 32'(ST_EMIT));
    end
    tick;
    @(negedge clk) begin
      check("lat_c2_valid", char_valid, 1);
      check("lat_c2_data", char_data, 8'h41);
    end
    letter_spacing = 1'b0;
    pending_space = 1'b1;
    word_gap();

    // O with letter_spacing held through the gap: one space only
    send_string("---", 1'b0);
    exp_q.push_back(8'h4F);
    letter_spacing = 1'b1;
    word_gap();
    repeat (2 * WORD_GAP) tick;
    letter_spacing = 1'b0;
    check("after_space_state", dbg_state, 32'(ST_IDLE));

    // Overflow length, then short presses inside a letter
    letter("......", 8'h3F);
    send_sym(SYM_DOT, 1'b0);
    send_sym(2'b00, 1'b0);
    send_sym(2'b11, 1'b0);
    close_letter(8'h45, 1'b0, 1'b0);
    word_gap();

    // Table of directed vectors
    for (int i = 0; i < 12; i++) begin
      letter(vecs[i].syms, vecs[i].exp);
      repeat ($urandom_range(0, 3)) tick;
    end
    word_gap();

    // ls_rise in the same cycle as the last capture includes that symbol
    send_string(".-", 1'b1);
    close_letter(8'h41, 1'b1, 1'b0);
    word_gap();

    // Overrun: five letters into a four-entry FIFO with no consumer
    char_ready = 1'b0;
    letter(".-", 8'h41);
    letter("-...", 8'h42);
    letter("-.-.", 8'h43);
    letter("-..", 8'h44);
    letter(".", 8'h45);
    @(negedge clk) begin
      check("ovr_set", overrun, 32'(exp_ovr));
      check("ovr_head", char_data, 8'h41);
    end
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    exp_ovr = 1'b0;
    @(negedge clk) check("ovr_clear", overrun, 0);
    char_ready = 1'b1;
    word_gap();
    check("ovr_drained", exp_q.size(), 0);

    // Full FIFO with a pop and an EMIT in the same cycle: nothing dropped
    char_ready = 1'b0;
    letter("....", 8'h48);
    letter("..", 8'h49);
    letter(".---", 8'h4A);
    letter("-.-", 8'h4B);
    send_string(".-..", 1'b0);
    close_letter(8'h4C, 1'b0, 1'b1);
    @(negedge clk) check("full_pop_push_ovr", overrun, 0);
    word_gap();
    check("full_pop_drained", exp_q.size(), 0);

    // Asynchronous reset mid-letter with a character queued
    char_ready = 1'b0;
    letter(".", 8'h45);
    repeat (3) tick;
    @(negedge clk) check("pre_rst_valid", char_valid, 1);
    send_sym(SYM_DOT, 1'b0);
    send_sym(SYM_DASH, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", char_valid, 0);
    check("async_rst_state", dbg_state, 32'(ST_IDLE));
    exp_q.delete();
    exp_ovr = 1'b0;
    pending_space = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    char_ready = 1'b1;
    letter("-", 8'h54);
    word_gap();

    // Random letters, invalid patterns, short presses and gaps
    for (int n = 0; n < 40; n++) begin
      s = "";
      r = $urandom_range(0, 9);
      if (r < 7) begin
        s = mc_tab[$urandom_range(0, 35)];
      end else begin
        nl = (r == 7) ? $urandom_range(1, 4) : $urandom_range(6, 7);
        for (int k = 0; k < nl; k++) s = {s, ($urandom_range(0, 1) != 0) ? "-" : "."};
      end
      if ($urandom_range(0, 3) == 0) send_sym(($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11, 1'b0);
      letter(s, model_decode(s));
      if ($urandom_range(0, 4) == 0) word_gap();
      else repeat ($urandom_range(0, 5)) tick;
    end
    if (pending_space) word_gap();

    // Final state
    @(negedge clk) begin
      check("end_queue_empty", exp_q.size(), 0);
      check("end_valid", char_valid, 0);
      check("end_overrun", overrun, 32'(exp_ovr));
      check("end_state", dbg_state, 32'(ST_IDLE));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
